cu_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational control unit/ALU.
- Accepts packed instructions {opcode, operand A, operand B} over a valid/ready handshake and executes them in a 2-stage pipeline (decode register, execute register).
- Returns W-bit results over a valid/ready handshake and keeps a count of executed instructions.
- Sits between the instruction source and the result consumer/register file.

---
 rtl/cu_pipe_if.sv | 42 ++++
 rtl/cu_pipe.sv | 153 +++++++++++++++
 tb/tb_cu_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cu_pipe_if.sv
// Handshake bundle for cu_pipe: instruction input, result output and status.
// Flag outputs exist only when CU_PIPE_FLAGS_EN is defined.
interface cu_pipe_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) ();
  localparam int unsigned IW = 2 * W + 3;

  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [CNT_W-1:0] op_count;
  logic             busy;
`ifdef CU_PIPE_FLAGS_EN
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_result, op_count, busy, out_carry, out_zero, out_neg
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_result, op_count, busy, out_carry, out_zero, out_neg
  );
`else
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_result, op_count, busy
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_result, op_count, busy
  );
`endif
endinterface

// File: rtl/cu_pipe.sv
// Two-stage pipelined control unit/ALU with valid/ready on both sides.
// Optional flag outputs (carry/zero/neg) are enabled by defining CU_PIPE_FLAGS_EN.
module cu_pipe #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  cu_pipe_if.slave   pipe_io
);
  localparam int unsigned IW = 2 * W + 3;

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpInc = 3'b011;
  localparam logic [2:0] OpDec = 3'b100;
  localparam logic [2:0] OpAnd = 3'b101;
  localparam logic [2:0] OpOr  = 3'b110;
  localparam logic [2:0] OpNot = 3'b111;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv;
  logic             out_xfer;
  logic [W:0]       alu_wide;
  logic [W-1:0]     alu_res;
  logic             alu_carry;

  assign s2_adv   = !s2_valid_q || pipe_io.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_xfer = s2_valid_q && pipe_io.out_ready;

  // Extra top bit doubles as carry (add/inc) or borrow (sub/dec); logic ops leave it 0.
  always_comb begin
    alu_wide = '0;
    case (s1_op_q)
      OpAdd:   alu_wide = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      OpSub:   alu_wide = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      OpInc:   alu_wide = {1'b0, s1_a_q} + {{W{1'b0}}, 1'b1};
      OpDec:   alu_wide = {1'b0, s1_a_q} - {{W{1'b0}}, 1'b1};
      OpAnd:   alu_wide = {1'b0, s1_a_q & s1_b_q};
      OpOr:    alu_wide = {1'b0, s1_a_q | s1_b_q};
      OpNot:   alu_wide = {1'b0, ~s1_a_q};
      default: alu_wide = '0;
    endcase
    alu_res   = alu_wide[W-1:0];
    alu_carry = alu_wide[W];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s1_adv) begin
      s1_valid_d = pipe_io.in_valid;
      if (pipe_io.in_valid) begin
        s1_op_d = pipe_io.in_instr[IW-1:2*W];
        s1_a_d  = pipe_io.in_instr[2*W-1:W];
        s1_b_d  = pipe_io.in_instr[W-1:0];
      end
    end
  end

  // NOPs are dropped on the way into stage 2 so the consumer never sees them.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q && (s1_op_q != OpNop);
      if (s1_valid_q && (s1_op_q != OpNop)) begin
        res_d = alu_res;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpNop;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pipe_io.in_ready   = s1_adv;
  assign pipe_io.out_valid  = s2_valid_q;
  assign pipe_io.out_result = res_q;
  assign pipe_io.op_count   = cnt_q;
  assign pipe_io.busy       = s1_valid_q || s2_valid_q;

`ifdef CU_PIPE_FLAGS_EN
  logic carry_q, carry_d;
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Flags load together with the result so they hold under backpressure.
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (s2_adv && s1_valid_q && (s1_op_q != OpNop)) begin
      carry_d = alu_carry;
      zero_d  = (alu_res == '0);
      neg_d   = alu_res[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign pipe_io.out_carry = carry_q;
  assign pipe_io.out_zero  = zero_q;
  assign pipe_io.out_neg   = neg_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif
endmodule

// File: tb/tb_cu_pipe.sv
// Self-checking bench for cu_pipe: directed scenarios plus random traffic
// scored against an arithmetic reference model and an expected-result queue.
module tb_cu_pipe;
  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IW    = 2 * W + 3;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    int           acc_edge;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cu_pipe_if #(.W(W), .CNT_W(CNT_W)) bus ();
  cu_pipe #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .pipe_io(bus));

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  int unsigned model_cnt = 0;
  bit          strict_lat = 1'b0;
  exp_t        q[$];
  logic [W-1:0] rx[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int ia = int'(a);
    int ib = int'(b);
    int m  = 1 << W;
    int r  = 0;
    case (op)
      3'd1: r = ia + ib;
      3'd2: r = ia - ib;
      3'd3: r = ia + 1;
      3'd4: r = ia - 1;
      3'd5: r = ia & ib;
      3'd6: r = ia | ib;
      3'd7: r = m - 1 - ia;
      default: r = 0;
    endcase
    e.carry    = (op >= 3'd1 && op <= 3'd4) && (r < 0 || r >= m);
    r          = ((r % m) + m) % m;
    e.res      = r[W-1:0];
    e.acc_edge = 0;
    return e;
  endfunction

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [IW-1:0] rnd_instr(input bit allow_nop);
    logic [31:0] r = $urandom;
    logic [2:0]  op = r[2*W+2:2*W];
    if (!allow_nop && op == 3'd0) op = 3'(1 + $urandom_range(0, 6));
    return {op, r[2*W-1:0]};
  endfunction

  // One clock: drive inputs, sample at the falling edge, score, then step past the rising edge.
  task automatic cycle(input logic iv, input logic [IW-1:0] ins, input logic ordy,
                       output logic acc, output logic ir);
    logic otx;
    exp_t e;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    @(negedge clk);
    ir  = bus.in_ready;
    acc = bus.in_valid && bus.in_ready;
    otx = bus.out_valid && bus.out_ready;
    if (strict_lat && q.size() > 0 && (q[0].acc_edge + 2 == edge_cnt + 1))
      chk("due_valid", bus.out_valid, 1'b1);
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", bus.out_valid, 1'b0);
      end else begin
        chk("result", bus.out_result, q[0].res);
`ifdef CU_PIPE_FLAGS_EN
        chk("carry", bus.out_carry, q[0].carry);
        chk("zero", bus.out_zero, q[0].res == '0);
        chk("neg", bus.out_neg, q[0].res[W-1]);
`endif
      end
    end
    if (otx && q.size() > 0) begin
      if (strict_lat) chk("latency", edge_cnt + 1, q[0].acc_edge + 2);
      else if (edge_cnt + 1 < q[0].acc_edge + 2) chk("early_output", edge_cnt + 1, q[0].acc_edge + 2);
      rx.push_back(bus.out_result);
      void'(q.pop_front());
      model_cnt++;
    end
    if (acc && ins[IW-1:2*W] != 3'd0) begin
      e = model(ins[IW-1:2*W], ins[2*W-1:W], ins[W-1:0]);
      e.acc_edge = edge_cnt + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("op_count", bus.op_count, model_cnt[CNT_W-1:0]);
  endtask

  initial begin
    logic         acc, ir;
    int           idx;
    logic [W-1:0] dir_exp[7];
    logic [IW-1:0] bp_ins[5];

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_op_count", bus.op_count, '0);
    chk("rst_out_result", bus.out_result, '0);
`ifdef CU_PIPE_FLAGS_EN
    chk("rst_flags", {bus.out_carry, bus.out_zero, bus.out_neg}, 3'b000);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Directed opcode sweep with A=0x23, B=0x14.
    dir_exp = '{8'h37, 8'h0F, 8'h24, 8'h22, 8'h00, 8'h37, 8'hDC};
    strict_lat = 1'b1;
    rx.delete();
    for (int op = 1; op <= 7; op++) begin
      cycle(1'b1, mk(3'(op), 8'h23, 8'h14), 1'b1, acc, ir);
      chk("sweep_in_ready", ir, 1'b1);
    end
    repeat (3) cycle(1'b0, '0, 1'b1, acc, ir);
    chk("sweep_beats", rx.size(), 7);
    for (int i = 0; i < 7 && i < rx.size(); i++) chk("sweep_value", rx[i], dir_exp[i]);
    chk("sweep_op_count", bus.op_count, 16'd7);

    // Back-to-back stream of 10.
    rx.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, rnd_instr(1'b0), 1'b1, acc, ir);
      chk("stream_in_ready", ir, 1'b1);
    end
    repeat (3) cycle(1'b0, '0, 1'b1, acc, ir);
    chk("stream_beats", rx.size(), 10);

    // Backpressure: consumer stalls for 5 cycles while the source keeps offering.
    strict_lat = 1'b0;
    rx.delete();
    for (int i = 0; i < 5; i++) bp_ins[i] = rnd_instr(1'b0);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, bp_ins[idx], 1'b0, acc, ir);
      chk("bp_in_ready", ir, c < 2);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    for (int c = 0; c < 30 && (idx < 5 || q.size() > 0); c++) begin
      cycle(idx < 5, (idx < 5) ? bp_ins[idx] : '0, 1'b1, acc, ir);
      if (acc) idx++;
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_beats", rx.size(), 5);

    // NOP between two ADDs with wrap-around.
    strict_lat = 1'b1;
    rx.delete();
    idx = int'(model_cnt);
    cycle(1'b1, mk(3'd1, 8'hFF, 8'h01), 1'b1, acc, ir);
    cycle(1'b1, mk(3'd0, 8'h55, 8'hAA), 1'b1, acc, ir);
    cycle(1'b1, mk(3'd1, 8'hFF, 8'h01), 1'b1, acc, ir);
    repeat (3) cycle(1'b0, '0, 1'b1, acc, ir);
    chk("nop_beats", rx.size(), 2);
    chk("nop_count_delta", int'(bus.op_count) - idx, 2);

    // INC of all-ones, DEC of zero.
    rx.delete();
    cycle(1'b1, mk(3'd3, 8'hFF, 8'h00), 1'b1, acc, ir);
    cycle(1'b1, mk(3'd4, 8'h00, 8'h00), 1'b1, acc, ir);
    repeat (3) cycle(1'b0, '0, 1'b1, acc, ir);
    chk("incdec_beats", rx.size(), 2);
    if (rx.size() == 2) begin
      chk("inc_wrap", rx[0], 8'h00);
      chk("dec_wrap", rx[1], 8'hFF);
    end

    // Random traffic with NOPs and random backpressure.
    strict_lat = 1'b0;
    for (int c = 0; c < 300; c++)
      cycle($urandom_range(0, 9) < 7, rnd_instr(1'b1), $urandom_range(0, 9) < 6, acc, ir);
    repeat (6) cycle(1'b0, '0, 1'b1, acc, ir);
    chk("rand_drained", q.size(), 0);
    chk("rand_idle_busy", bus.busy, 1'b0);

    // Reset with both stages occupied.
    cycle(1'b1, mk(3'd1, 8'h01, 8'h02), 1'b0, acc, ir);
    cycle(1'b1, mk(3'd2, 8'h09, 8'h03), 1'b0, acc, ir);
    chk("pre_reset_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 1'b0);
    chk("async_busy", bus.busy, 1'b0);
    chk("async_op_count", bus.op_count, '0);
    q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    strict_lat = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b1, acc, ir);
    rx.delete();
    cycle(1'b1, mk(3'd6, 8'hA0, 8'h05), 1'b1, acc, ir);
    repeat (3) cycle(1'b0, '0, 1'b1, acc, ir);
    chk("post_reset_beats", rx.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
